// File: rtl/somador_5bits_pkg.sv
// Shared definitions for the fetch-path incrementer and its bit-slice.
package somador_5bits_pkg;

  // Default operand width of the incrementer.
  localparam int DEFAULT_WIDTH = 5;

  // Fetch-path step added to the PC on every sequential fetch.
  localparam int PC_STEP = 4;

  // Flag bundle captured alongside the registered sum.
  typedef struct packed {
    logic cout;
    logic ovf;
  } flags_t;

  // Carry generation of one adder slice: set when at least two inputs are set.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/somador_5bits_full_adder_1b.sv
// One-bit full adder: the repeated slice of the ripple-carry chain.
module full_adder_1b
  import somador_5bits_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum bit is the parity of the three inputs; carry is their majority.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = majority(a, b, cin);
  end

endmodule

// File: rtl/somador_5bits.sv
// Ripple-carry adder used as the PC incrementer, with a clocked status
// stage holding the last sum, carry-out and signed overflow.
// There is no handshake: the combinational outputs are valid whenever the
// inputs are stable, and the registered outputs refresh on every rising
// clock edge while reset is high.
module somador_5bits
  import somador_5bits_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  input  logic             clk,
  input  logic             reset
);

  // c[i] is the carry into bit i; c[0] is the external carry-in.
  logic [WIDTH:0] c;
  flags_t         flags_d;
  flags_t         flags_q;

  assign c[0] = cin;

  // One full-adder slice per bit, chained through c.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    full_adder_1b u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // Carry out of the MSB and signed overflow (carry into MSB differs from carry out).
  always_comb begin
    flags_d.cout = c[WIDTH];
    flags_d.ovf  = c[WIDTH] ^ c[WIDTH-1];
  end

  assign cout = flags_d.cout;
  assign ovf  = flags_d.ovf;

  // Status stage: clears immediately on reset, otherwise captures the adder every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      sum_q   <= sum;
      flags_q <= flags_d;
    end
  end

  assign cout_q = flags_q.cout;
  assign ovf_q  = flags_q.ovf;

endmodule

// File: tb/tb_somador_5bits.sv
// Bench for the PC incrementer: directed vectors plus an exhaustive sweep,
// checked through expected queues consumed by independent monitors.
module tb_somador_5bits;

  localparam int WIDTH = 5;
  localparam int CW    = WIDTH + 2;  // packed {cout, ovf, sum}

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             cout;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             clk;
  logic             reset;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] comb_exp_q[$];
  string         comb_name_q[$];
  logic [CW-1:0] reg_exp_q[$];
  string         reg_name_q[$];

  event comb_ev;
  event reg_ev;

  somador_5bits #(.WIDTH(WIDTH)) dut (
    .a      (a),
    .b      (b),
    .cin    (cin),
    .cout   (cout),
    .sum    (sum),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q),
    .clk    (clk),
    .reset  (reset)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor for combinational outputs.
  initial begin
    forever begin
      @(comb_ev);
      checks++;
      if (comb_exp_q.size() == 0) begin
        errors++;
        $display("FAIL comb_underflow: got check request, required queued expectation");
      end else begin
        logic [CW-1:0] exp_v;
        string         nm;
        exp_v = comb_exp_q.pop_front();
        nm    = comb_name_q.pop_front();
        if ({cout, ovf, sum} !== exp_v) begin
          errors++;
          $display("FAIL %s: got cout=%0b ovf=%0b sum=%0d, required cout=%0b ovf=%0b sum=%0d",
                   nm, cout, ovf, sum, exp_v[CW-1], exp_v[CW-2], exp_v[WIDTH-1:0]);
        end
      end
    end
  end

  // Registered outputs are observed 1ns after each rising edge when something is expected.
  always @(posedge clk) begin
    #1;
    if (reg_exp_q.size() != 0) ->reg_ev;
  end

  // Monitor for registered outputs.
  initial begin
    forever begin
      @(reg_ev);
      checks++;
      if (reg_exp_q.size() == 0) begin
        errors++;
        $display("FAIL reg_underflow: got check request, required queued expectation");
      end else begin
        logic [CW-1:0] exp_v;
        string         nm;
        exp_v = reg_exp_q.pop_front();
        nm    = reg_name_q.pop_front();
        if ({cout_q, ovf_q, sum_q} !== exp_v) begin
          errors++;
          $display("FAIL %s: got cout_q=%0b ovf_q=%0b sum_q=%0d, required cout_q=%0b ovf_q=%0b sum_q=%0d",
                   nm, cout_q, ovf_q, sum_q, exp_v[CW-1], exp_v[CW-2], exp_v[WIDTH-1:0]);
        end
      end
    end
  end

  // Driver: apply operands, then request a combinational check.
  task automatic drive_comb(input int av, input int bv, input int cv,
                            input int es, input int ec, input int eo, input string nm);
    a   = WIDTH'(av);
    b   = WIDTH'(bv);
    cin = cv[0];
    #1;
    comb_exp_q.push_back({ec[0], eo[0], WIDTH'(es)});
    comb_name_q.push_back(nm);
    ->comb_ev;
    #1;
  endtask

  // Driver: expect a registered value after the next rising edge.
  task automatic expect_edge(input int es, input int ec, input int eo, input string nm);
    reg_exp_q.push_back({ec[0], eo[0], WIDTH'(es)});
    reg_name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  // Driver: check registered outputs right now, between edges.
  task automatic expect_now(input int es, input int ec, input int eo, input string nm);
    reg_exp_q.push_back({ec[0], eo[0], WIDTH'(es)});
    reg_name_q.push_back(nm);
    ->reg_ev;
    #1;
  endtask

  // Stimulus
  initial begin
    reset = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #2;
    expect_now(0, 0, 0, "reset_state");

    @(negedge clk);
    reset = 1'b1;

    // PC + 4 from zero
    @(negedge clk);
    drive_comb(0, 4, 0, 4, 0, 0, "pc0_plus4");
    expect_edge(4, 0, 0, "pc0_plus4_q");

    // PC wrap 28 + 4
    @(negedge clk);
    drive_comb(28, 4, 0, 0, 1, 0, "pc_wrap");
    expect_edge(0, 1, 0, "pc_wrap_q");

    // carry-in ripple through all ones
    @(negedge clk);
    drive_comb(31, 0, 1, 0, 1, 0, "all_ones_cin");
    drive_comb(15, 15, 1, 31, 0, 1, "half_plus_half_cin");
    expect_edge(31, 0, 1, "half_plus_half_cin_q");

    // signed overflow cases
    @(negedge clk);
    drive_comb(12, 4, 0, 16, 0, 1, "pos_ovf");
    expect_edge(16, 0, 1, "pos_ovf_q");
    @(negedge clk);
    drive_comb(16, 16, 0, 0, 1, 1, "neg_ovf");
    expect_edge(0, 1, 1, "neg_ovf_q");
    @(negedge clk);
    drive_comb(20, 11, 0, 31, 0, 0, "no_carry_mix");

    // reset mid-run
    @(negedge clk);
    drive_comb(4, 4, 0, 8, 0, 0, "load8");
    expect_edge(8, 0, 0, "load8_q");
    @(negedge clk);
    reset = 1'b0;
    #1;
    expect_now(0, 0, 0, "async_reset_clear");
    drive_comb(1, 2, 0, 3, 0, 0, "comb_during_reset");
    expect_edge(0, 0, 0, "held_in_reset");
    @(negedge clk);
    reset = 1'b1;
    drive_comb(9, 4, 1, 14, 0, 0, "after_release");
    expect_edge(14, 0, 0, "reload_after_release");

    // exhaustive sweep
    for (int ai = 0; ai < 32; ai++) begin
      for (int bi = 0; bi < 32; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          int tot;
          int sa;
          int sb;
          int ss;
          int eo;
          tot = ai + bi + ci;
          sa  = (ai >= 16) ? ai - 32 : ai;
          sb  = (bi >= 16) ? bi - 32 : bi;
          ss  = sa + sb + ci;
          eo  = (ss > 15 || ss < -16) ? 1 : 0;
          drive_comb(ai, bi, ci, tot % 32, tot / 32, eo, "sweep");
        end
      end
    end

    // every queued expectation must have been consumed
    #20;
    checks++;
    if (comb_exp_q.size() + reg_exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d pending, required 0",
               comb_exp_q.size() + reg_exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/somador_5bits.md
# somador_5bits

Parameterised ripple-carry adder, default 5 bits, used as the program-counter incrementer in the instruction-fetch path (computes PC + 4). The sum and carry-out are combinational, so the next PC is available in the same cycle the PC register updates. A clocked status stage also captures the sum, carry-out and signed overflow for debug and flag use.

## Interface
- `WIDTH`, default 5: operand and sum width in bits; must be ≥ 1.
- `clk`  input  1: clock for the status registers only.
- `reset`  input  1: asynchronous, active-low; clears all registered outputs.
- `a`  input  WIDTH: operand A (PC value in the fetch path).
- `b`  input  WIDTH: operand B (constant 5'b00100 in the fetch path).
- `cin`  input  1: carry-in.
- `cout`  output  1: combinational carry-out of the MSB.
- `sum`  output  WIDTH: combinational (a + b + cin) mod 2^WIDTH.
- `ovf`  output  1: combinational signed overflow (carry into MSB XOR carry out of MSB).
- `sum_q`  output  WIDTH: `sum` registered.
- `cout_q`  output  1: `cout` registered.
- `ovf_q`  output  1: `ovf` registered.
- Declaration order is a, b, cin, cout, sum, ovf, sum_q, cout_q, ovf_q, clk, reset. This keeps existing five-port positional instantiations (a, b, cin, cout, sum) valid. New instantiations connect by name.

## Operation
- {cout, sum} = a + b + cin, computed exactly at WIDTH+1 bits with no truncation before the carry.
- The carry is a ripple chain: c[0] = cin, and c[i+1] = majority(a[i], b[i], c[i]).
- sum[i] = a[i] ^ b[i] ^ c[i]; cout = c[WIDTH]; ovf = c[WIDTH] ^ c[WIDTH-1].
- Overflow wraps modulo 2^WIDTH. For example, 28 + 4 gives sum 0 and cout 1. No saturation.
- Combinational outputs depend only on a, b and cin. They are independent of clk and reset, and must not create a latch or any path to the registers.
- Registered outputs are sum_q, cout_q and ovf_q.
  - On each rising clk edge while reset is high, they load sum, cout and ovf.
  - While reset is low, they are forced to 0 immediately and held at 0.

## Timing
- Combinational path a/b/cin → sum/cout/ovf has zero-cycle latency. The worst-case path is the full WIDTH-stage ripple from cin or a[0]/b[0] to cout.
- Registered outputs have 1-cycle latency: the value on sum_q after edge N reflects the inputs present just before edge N.
- Reset value of sum_q, cout_q and ovf_q is 0. Combinational outputs have no reset value and track their inputs during reset.
- Reset is asserted asynchronously: registered outputs clear without waiting for a clock edge.
- Reset release is sampled on clk. The first load occurs on the first rising edge with reset high.
- Reset asserted mid-operation clears the registered outputs at once. The combinational sum is unaffected.
- No handshake and no internal state beyond the three registers.

## Structure
- One sub-module, `full_adder_1b`, with ports (a, b, cin → s, cout). Instantiate WIDTH copies in a generate loop to form the chain.
- No shared package is needed. If one already exists, the fetch-path constant PC_STEP = 4 belongs in it, not in this block.

## Test plan
- a=0, b=4, cin=0 → sum=4, cout=0, ovf=0 combinationally. After one clock, sum_q=4.
- a=28, b=4, cin=0 → sum=0, cout=1 (PC wrap). After one clock, cout_q=1.
- a=31, b=0, cin=1 → sum=0, cout=1. Then a=15, b=15, cin=1 → sum=31, cout=0.
- Signed overflow: a=12, b=4 → sum=16, ovf=1. a=16, b=16 → sum=0, cout=1, ovf=1.
- Reset mid-run: load sum_q=8, then drive reset low between clock edges → sum_q, cout_q and ovf_q are 0 immediately while sum still follows the inputs. Release reset → the next edge reloads.
- Exhaustive sweep of all 2^11 (a, b, cin) combinations → {cout, sum} equals the integer sum every time.
